tcm_sequencer: RTL and testbench

//  Program sequencer for the two-counter machine. Fetches 8-bit instructions from a sync-read

---
 rtl/tcm_pkg.sv | 22 ++
 rtl/tcm_decode.sv | 25 ++
 rtl/tcm_sequencer.sv | 120 ++++++++++++
 tb/tb_tcm_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tcm_pkg.sv
// Shared encodings for the two-counter machine sequencer: opcodes, IR field
// positions and FSM state codes.
package tcm_pkg;

  localparam logic [1:0] OP_INC   = 2'b00;
  localparam logic [1:0] OP_JZDEC = 2'b01;
  localparam logic [1:0] OP_JMP   = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam int OP_HI   = 7;
  localparam int OP_LO   = 6;
  localparam int REG_BIT = 5;
  localparam int TGT_HI  = 4;
  localparam int TGT_LO  = 0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_EXEC  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

endpackage

// File: rtl/tcm_decode.sv
// Combinational instruction decoder: splits the 8-bit IR into one-hot
// opcode flags, the register select and the jump target.
module tcm_decode
  import tcm_pkg::*;
(
  input  logic [7:0] ir,
  output logic       is_inc,
  output logic       is_jzdec,
  output logic       is_jmp,
  output logic       is_halt,
  output logic       reg_sel,
  output logic [4:0] target
);

  logic [1:0] op;

  assign op       = ir[OP_HI:OP_LO];
  assign is_inc   = (op == OP_INC);
  assign is_jzdec = (op == OP_JZDEC);
  assign is_jmp   = (op == OP_JMP);
  assign is_halt  = (op == OP_HALT);
  assign reg_sel  = ir[REG_BIT];
  assign target   = ir[TGT_HI:TGT_LO];

endmodule

// File: rtl/tcm_sequencer.sv
// Program sequencer for the two-counter machine: fetch/load/execute FSM that
// drives the A/B regfile and halts on HALT, counter overflow or watchdog.
module tcm_sequencer
  import tcm_pkg::*;
#(
  parameter int PC_W      = 5,
  parameter int DATA_W    = 8,
  parameter int MAX_STEPS = 1023
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [PC_W-1:0]   pc,
  output logic [9:0]        steps,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [7:0]        imem_data,
  output logic              rf_we,
  output logic              rf_dest,
  output logic              rf_srcA,
  output logic [DATA_W-1:0] rf_wb,
  input  logic [DATA_W-1:0] rf_r1
);

  logic [2:0]        state;
  logic [7:0]        ir;
  logic              is_inc, is_jzdec, is_jmp, is_halt, reg_sel;
  logic [4:0]        target;
  logic [PC_W-1:0]   target_pc;
  logic [PC_W-1:0]   pc_next;
  logic [9:0]        steps_inc;
  logic [DATA_W-1:0] wb_val;
  logic              r1_zero, r1_max, overflow, write_ok, watchdog_hit;

  tcm_decode u_decode (
    .ir       (ir),
    .is_inc   (is_inc),
    .is_jzdec (is_jzdec),
    .is_jmp   (is_jmp),
    .is_halt  (is_halt),
    .reg_sel  (reg_sel),
    .target   (target)
  );

  assign target_pc    = PC_W'(target);
  assign r1_zero      = (rf_r1 == '0);
  assign r1_max       = &rf_r1;
  assign overflow     = is_inc && r1_max;
  assign write_ok     = is_inc ? !r1_max : (is_jzdec && !r1_zero);
  assign wb_val       = is_inc ? rf_r1 + DATA_W'(1) : rf_r1 - DATA_W'(1);
  assign steps_inc    = (&steps) ? steps : steps + 10'd1;
  assign watchdog_hit = !is_halt && (steps_inc == 10'(MAX_STEPS));

  always_comb begin
    pc_next = pc;
    if (is_inc)
      pc_next = pc + PC_W'(1);
    else if (is_jzdec)
      pc_next = r1_zero ? target_pc : pc + PC_W'(1);
    else if (is_jmp)
      pc_next = target_pc;
  end

  // Reset gates the write so an instruction caught mid-EXEC leaves the regfile untouched.
  assign busy      = (state == S_FETCH) || (state == S_LOAD) || (state == S_EXEC);
  assign done      = (state == S_HALT);
  assign imem_addr = pc;
  assign rf_srcA   = reg_sel;
  assign rf_dest   = reg_sel;
  assign rf_we     = (state == S_EXEC) && !reset && write_ok;
  assign rf_wb     = (state == S_EXEC) ? wb_val : '0;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= '0;
      steps <= '0;
      ir    <= '0;
      error <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc    <= '0;
            steps <= '0;
            error <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          ir    <= imem_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          steps <= steps_inc;
          // Overflow halts before the pc moves so the faulting address stays visible.
          if (overflow) begin
            error <= 1'b1;
            state <= S_HALT;
          end else begin
            pc <= pc_next;
            if (is_halt) begin
              state <= S_HALT;
            end else if (watchdog_hit) begin
              error <= 1'b1;
              state <= S_HALT;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcm_sequencer.sv
// Scoreboard bench for tcm_sequencer: models the program ROM and A/B regfile,
// queues expected writes and halt results, and a monitor checks them.
module tb_tcm_sequencer;

  localparam int PC_W      = 5;
  localparam int DATA_W    = 8;
  localparam int MAX_STEPS = 16;

  typedef struct {
    logic        dest;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic        err;
    logic [4:0]  pc;
    logic [9:0]  steps;
    logic        chk_steps;
    logic [7:0]  a;
    logic [7:0]  b;
  } halt_t;

  logic              CLK = 1'b0;
  logic              reset, start;
  logic              busy, done, error;
  logic [PC_W-1:0]   pc, imem_addr;
  logic [9:0]        steps;
  logic [7:0]        imem_data;
  logic              rf_we, rf_dest, rf_srcA;
  logic [DATA_W-1:0] rf_wb, rf_r1;

  logic [7:0]        rom [32];
  logic [7:0]        reg_a, reg_b;
  logic              preset_req;
  logic [7:0]        preset_a, preset_b;

  wr_t   wr_q[$];
  halt_t halt_q[$];
  wr_t   mon_wr;
  halt_t mon_halt;
  logic  prev_done = 1'b0;
  int    checks = 0;
  int    passes = 0;
  int    cycles;

  always #5 CLK = ~CLK;

  tcm_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .MAX_STEPS(MAX_STEPS)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .pc        (pc),
    .steps     (steps),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .rf_we     (rf_we),
    .rf_dest   (rf_dest),
    .rf_srcA   (rf_srcA),
    .rf_wb     (rf_wb),
    .rf_r1     (rf_r1)
  );

  // Sync-read ROM and the A/B regfile the sequencer talks to.
  always @(posedge CLK) imem_data <= rom[imem_addr];

  always @(posedge CLK) begin
    if (preset_req) begin
      reg_a <= preset_a;
      reg_b <= preset_b;
    end else if (rf_we) begin
      if (rf_dest) reg_b <= rf_wb;
      else         reg_a <= rf_wb;
    end
  end

  assign rf_r1 = rf_srcA ? reg_b : reg_a;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  always @(negedge CLK) begin
    if (rf_we) begin
      if (wr_q.size() == 0) begin
        check_output("unexpected rf_we", 1, 0);
      end else begin
        mon_wr = wr_q.pop_front();
        check_output("rf_dest", rf_dest, mon_wr.dest);
        check_output("rf_wb", rf_wb, mon_wr.data);
      end
    end
    if (done && !prev_done) begin
      if (halt_q.size() == 0) begin
        check_output("unexpected halt", 1, 0);
      end else begin
        mon_halt = halt_q.pop_front();
        check_output("halt error", error, mon_halt.err);
        check_output("halt pc", pc, mon_halt.pc);
        if (mon_halt.chk_steps) check_output("halt steps", steps, mon_halt.steps);
        check_output("reg A", reg_a, mon_halt.a);
        check_output("reg B", reg_b, mon_halt.b);
      end
    end
    prev_done = done;
  end

  task automatic exp_wr(input logic d, input logic [7:0] v);
    wr_q.push_back('{d, v});
  endtask

  task automatic exp_halt(input logic e, input logic [4:0] p, input logic [9:0] s,
                          input logic cs, input logic [7:0] a, input logic [7:0] b);
    halt_q.push_back('{e, p, s, cs, a, b});
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 8'hC0;
  endtask

  task automatic set_regs(input logic [7:0] a, input logic [7:0] b);
    @(posedge CLK);
    #1 preset_a = a; preset_b = b; preset_req = 1'b1;
    @(posedge CLK);
    #1 preset_req = 1'b0;
  endtask

  // Runs the loaded program; optionally pokes start while busy. Returns cycles from start to done.
  task automatic apply_stimulus(input logic poke_busy, output int n);
    @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge CLK);
      #1 n++;
      start = poke_busy && (n >= 1) && (n <= 7);
      if (poke_busy && n == 4) check_output("busy during run", busy, 1);
    end
    start = 1'b0;
    if (!done) check_output("run timeout", 0, 1);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; preset_req = 1'b0; preset_a = '0; preset_b = '0;
    clear_rom();
    repeat (3) @(posedge CLK);
    #1;
    check_output("reset busy", busy, 0);
    check_output("reset done", done, 0);
    check_output("reset error", error, 0);
    check_output("reset pc", pc, 0);
    check_output("reset steps", steps, 0);
    check_output("reset rf_we", rf_we, 0);
    check_output("reset rf_wb", rf_wb, 0);
    check_output("reset imem_addr", imem_addr, 0);
    reset = 1'b0;

    // Straight-line program: INC A, INC A, INC B, HALT.
    set_regs(8'd0, 8'd0);
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h20; rom[3] = 8'hC0;
    exp_wr(1'b0, 8'd1); exp_wr(1'b0, 8'd2); exp_wr(1'b1, 8'd1);
    exp_halt(1'b0, 5'd3, 10'd4, 1'b1, 8'd2, 8'd1);
    apply_stimulus(1'b0, cycles);
    check_output("t1 cycles to done", cycles, 12);

    // Transfer loop: A counts down to 0 while B counts up.
    set_regs(8'd0, 8'd0);
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00;
    rom[3] = 8'h46; rom[4] = 8'h20; rom[5] = 8'h83; rom[6] = 8'hC0;
    exp_wr(1'b0, 8'd1); exp_wr(1'b0, 8'd2); exp_wr(1'b0, 8'd3);
    exp_wr(1'b0, 8'd2); exp_wr(1'b1, 8'd1);
    exp_wr(1'b0, 8'd1); exp_wr(1'b1, 8'd2);
    exp_wr(1'b0, 8'd0); exp_wr(1'b1, 8'd3);
    exp_halt(1'b0, 5'd6, 10'd14, 1'b1, 8'd0, 8'd3);
    apply_stimulus(1'b0, cycles);

    // Overflow: A is preloaded to 254, first INC reaches 255, second INC faults at pc 1.
    set_regs(8'd254, 8'd0);
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'hC0;
    exp_wr(1'b0, 8'd255);
    exp_halt(1'b1, 5'd1, 10'd0, 1'b0, 8'd255, 8'd0);
    apply_stimulus(1'b0, cycles);

    // Watchdog: endless JMP 0 stops after MAX_STEPS executions.
    clear_rom();
    rom[0] = 8'h80;
    exp_halt(1'b1, 5'd0, 10'd16, 1'b1, 8'd255, 8'd0);
    apply_stimulus(1'b0, cycles);
    check_output("t4 cycles to done", cycles, 48);

    // Reset during EXEC of INC B must abort the write.
    set_regs(8'd0, 8'd0);
    clear_rom();
    rom[0] = 8'h20;
    @(posedge CLK);
    #1 start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    check_output("t5 exec rf_we", rf_we, 1);
    check_output("t5 exec rf_wb", rf_wb, 1);
    reset = 1'b1;
    #1 check_output("t5 rf_we gated", rf_we, 0);
    @(posedge CLK);
    #1 reset = 1'b0;
    check_output("t5 busy", busy, 0);
    check_output("t5 done", done, 0);
    check_output("t5 pc", pc, 0);
    check_output("t5 steps", steps, 0);
    check_output("t5 rf_we", rf_we, 0);
    check_output("t5 rf_dest", rf_dest, 0);
    repeat (3) @(posedge CLK);
    #1;
    check_output("t5 stays idle", busy, 0);
    check_output("t5 reg B untouched", reg_b, 0);

    // start pokes while busy are ignored; a restart from HALT keeps register values.
    clear_rom();
    rom[0] = 8'h00; rom[1] = 8'h20; rom[2] = 8'hC0;
    exp_wr(1'b0, 8'd1); exp_wr(1'b1, 8'd1);
    exp_halt(1'b0, 5'd2, 10'd3, 1'b1, 8'd1, 8'd1);
    apply_stimulus(1'b1, cycles);
    check_output("t6 cycles to done", cycles, 9);
    exp_wr(1'b0, 8'd2); exp_wr(1'b1, 8'd2);
    exp_halt(1'b0, 5'd2, 10'd3, 1'b1, 8'd2, 8'd2);
    apply_stimulus(1'b0, cycles);

    repeat (2) @(posedge CLK);
    #1;
    check_output("write queue drained", wr_q.size(), 0);
    check_output("halt queue drained", halt_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
